// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall detection and M/W operand forwarding.
// Optional 32-bit saturating bubble counter when BUBBLE_CNT_EN is defined.
module id_ex_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PC_D,
   input  logic [31:0] IR_D,
   input  logic [31:0] RD1_D,
   input  logic [31:0] RD2_D,
   input  logic [31:0] imm_D,
   input  logic        flush_in,
   input  logic        we_M,
   input  logic [4:0]  wa_M,
   input  logic [31:0] wd_M,
   input  logic        we_W,
   input  logic [4:0]  wa_W,
   input  logic [31:0] wd_W,
   output logic        stall_D,
   output logic [31:0] PC_E,
   output logic [31:0] IR_E,
   output logic [31:0] imm_E,
   output logic [31:0] RD1_E,
   output logic [31:0] RD2_E,
   output logic [4:0]  dst_E,
   output logic        valid_E
`ifdef BUBBLE_CNT_EN
   ,
   output logic [31:0] bubble_cnt
`endif
);
   logic [5:0]  op_d;
   logic [4:0]  dst_d;
   logic [4:0]  rs_e;
   logic [4:0]  rt_e;
   logic [31:0] rd1_q;
   logic [31:0] rd2_q;
   logic        bubble;

   always_comb begin
      op_d    = IR_D[31:26];
      dst_d   = (op_d == 6'h00 && IR_D != 32'd0) ? IR_D[15:11] :
                (op_d == 6'h0D || op_d == 6'h0F || op_d == 6'h23) ? IR_D[20:16] :
                (op_d == 6'h03) ? 5'd31 : 5'd0;
      stall_D = IR_E[31:26] == 6'h23 && dst_E != 5'd0 &&
                (dst_E == IR_D[25:21] || dst_E == IR_D[20:16]);
      bubble  = stall_D || flush_in;
      rs_e    = IR_E[25:21];
      rt_e    = IR_E[20:16];
      // MEM wins over WB; register 0 is never forwarded
      RD1_E   = (we_M && wa_M != 5'd0 && wa_M == rs_e) ? wd_M :
                (we_W && wa_W != 5'd0 && wa_W == rs_e) ? wd_W : rd1_q;
      RD2_E   = (we_M && wa_M != 5'd0 && wa_M == rt_e) ? wd_M :
                (we_W && wa_W != 5'd0 && wa_W == rt_e) ? wd_W : rd2_q;
   end

   always_ff @(posedge clk) begin
      if (!reset || bubble) begin
         PC_E    <= '0;
         IR_E    <= '0;
         imm_E   <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         dst_E   <= '0;
         valid_E <= 1'b0;
      end else begin
         PC_E    <= PC_D;
         IR_E    <= IR_D;
         imm_E   <= imm_D;
         rd1_q   <= RD1_D;
         rd2_q   <= RD2_D;
         dst_E   <= dst_d;
         valid_E <= 1'b1;
      end
   end

`ifdef BUBBLE_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset)
         bubble_cnt <= '0;
      else if (bubble && bubble_cnt != '1)
         bubble_cnt <= bubble_cnt + 32'd1;
   end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven directed vectors plus hand sequences for reset-mid-stall and counter saturation.
module tb_id_ex_stage;
   localparam logic [31:0] JAL   = 32'h0C000C00;
   localparam logic [31:0] ORI   = 32'h34070005;
   localparam logic [31:0] SW    = 32'hAC070000;
   localparam logic [31:0] LUI   = 32'h3C031234;
   localparam logic [31:0] LW    = 32'h8C080000;
   localparam logic [31:0] ADDU5 = 32'h00A65021;
   localparam logic [31:0] ADDU0 = 32'h00005821;
   localparam logic [31:0] ADDU8 = 32'h01084821;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] PC_D = '0, IR_D = '0, RD1_D = '0, RD2_D = '0, imm_D = '0;
   logic        flush_in = 1'b0;
   logic        we_M = 1'b0, we_W = 1'b0;
   logic [4:0]  wa_M = '0, wa_W = '0;
   logic [31:0] wd_M = '0, wd_W = '0;
   logic        stall_D, valid_E;
   logic [31:0] PC_E, IR_E, imm_E, RD1_E, RD2_E;
   logic [4:0]  dst_E;
`ifdef BUBBLE_CNT_EN
   logic [31:0] bubble_cnt;
`endif
   int ncmp = 0;
   int nerr = 0;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .PC_D(PC_D), .IR_D(IR_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
      .imm_D(imm_D), .flush_in(flush_in), .we_M(we_M), .wa_M(wa_M), .wd_M(wd_M),
      .we_W(we_W), .wa_W(wa_W), .wd_W(wd_W), .stall_D(stall_D), .PC_E(PC_E), .IR_E(IR_E),
      .imm_E(imm_E), .RD1_E(RD1_E), .RD2_E(RD2_E), .dst_E(dst_E), .valid_E(valid_E)
`ifdef BUBBLE_CNT_EN
      , .bubble_cnt(bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] ir, pc, rd1, rd2, imm;
      logic        flush, we_m;
      logic [4:0]  wa_m;
      logic [31:0] wd_m;
      logic        we_w;
      logic [4:0]  wa_w;
      logic [31:0] wd_w;
      logic        x_stall;
      logic [31:0] x_ir, x_pc;
      logic [4:0]  x_dst;
      logic        x_valid;
      logic [31:0] x_rd1, x_rd2, x_imm;
   } vec_t;

   vec_t vt[12];

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      ncmp++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vt[0]  = '{JAL, 32'h3000, 32'h11, 32'h22, 32'h44, 0, 0, 0, 0, 0, 0, 0,
                 0, JAL, 32'h3000, 31, 1, 32'h11, 32'h22, 32'h44};
      vt[1]  = '{ORI, 32'h3004, 32'h1, 32'h2, 32'h5, 0, 0, 0, 0, 0, 0, 0,
                 0, ORI, 32'h3004, 7, 1, 32'h1, 32'h2, 32'h5};
      vt[2]  = '{SW, 32'h3008, 32'h3, 32'h4, 32'h8, 0, 0, 0, 0, 1, 7, 32'h77,
                 0, SW, 32'h3008, 0, 1, 32'h3, 32'h77, 32'h8};
      vt[3]  = '{ADDU5, 32'h300C, 32'h5, 32'h6, 0, 0, 1, 5, 32'hAAAA0000, 1, 5, 32'h5555,
                 0, ADDU5, 32'h300C, 10, 1, 32'hAAAA0000, 32'h6, 0};
      vt[4]  = '{ADDU5, 32'h3010, 32'h5, 32'h6, 0, 0, 1, 6, 32'hBBBB, 1, 5, 32'h5555,
                 0, ADDU5, 32'h3010, 10, 1, 32'h5555, 32'hBBBB, 0};
      vt[5]  = '{ADDU0, 32'h3014, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 32'h1,
                 0, ADDU0, 32'h3014, 11, 1, 0, 0, 0};
      vt[6]  = '{LUI, 32'h3018, 32'h7, 32'h7, 32'h1234, 1, 1, 0, 32'hFFFFFFFF, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0};
      vt[7]  = '{LW, 32'h301C, 0, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, LW, 32'h301C, 8, 1, 0, 32'h99, 0};
      vt[8]  = '{ADDU8, 32'h3020, 32'hDEAD, 32'hBEEF, 0, 0, 0, 0, 0, 0, 0, 0,
                 1, 0, 0, 0, 0, 0, 0, 0};
      vt[9]  = '{ADDU8, 32'h3020, 32'hDEAD, 32'hBEEF, 0, 0, 0, 0, 0, 1, 8, 32'h1234,
                 0, ADDU8, 32'h3020, 9, 1, 32'h1234, 32'h1234, 0};
      vt[10] = '{LW, 32'h3024, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, LW, 32'h3024, 8, 1, 0, 0, 0};
      vt[11] = '{ADDU8, 32'h3028, 32'h1, 32'h2, 0, 1, 0, 0, 0, 0, 0, 0,
                 1, 0, 0, 0, 0, 0, 0, 0};

      // reset with flush and junk on D inputs
      IR_D = LW; PC_D = 32'h1000; RD1_D = 32'h5; flush_in = 1'b1;
      tick();
      tick();
      chk("rst IR_E", IR_E, 0);
      chk("rst PC_E", PC_E, 0);
      chk("rst RD1_E", RD1_E, 0);
      chk("rst valid_E", {31'd0, valid_E}, 0);
      chk("rst dst_E", {27'd0, dst_E}, 0);
`ifdef BUBBLE_CNT_EN
      chk("rst bubble_cnt", bubble_cnt, 0);
`endif
      reset = 1'b1;

      for (int i = 0; i < 12; i++) begin
         IR_D = vt[i].ir; PC_D = vt[i].pc; RD1_D = vt[i].rd1; RD2_D = vt[i].rd2; imm_D = vt[i].imm;
         flush_in = vt[i].flush;
         we_M = vt[i].we_m; wa_M = vt[i].wa_m; wd_M = vt[i].wd_m;
         we_W = vt[i].we_w; wa_W = vt[i].wa_w; wd_W = vt[i].wd_w;
         #1;
         chk($sformatf("v%0d stall_D", i), {31'd0, stall_D}, {31'd0, vt[i].x_stall});
         tick();
         chk($sformatf("v%0d IR_E", i), IR_E, vt[i].x_ir);
         chk($sformatf("v%0d PC_E", i), PC_E, vt[i].x_pc);
         chk($sformatf("v%0d dst_E", i), {27'd0, dst_E}, {27'd0, vt[i].x_dst});
         chk($sformatf("v%0d valid_E", i), {31'd0, valid_E}, {31'd0, vt[i].x_valid});
         chk($sformatf("v%0d RD1_E", i), RD1_E, vt[i].x_rd1);
         chk($sformatf("v%0d RD2_E", i), RD2_E, vt[i].x_rd2);
         chk($sformatf("v%0d imm_E", i), imm_E, vt[i].x_imm);
      end
`ifdef BUBBLE_CNT_EN
      chk("bubble_cnt after table", bubble_cnt, 3);
`endif

      // reset asserted while a load-use stall is pending
      flush_in = 1'b0; we_M = 1'b0; we_W = 1'b0;
      IR_D = LW; PC_D = 32'h302C;
      tick();
      chk("seq lw IR_E", IR_E, LW);
      IR_D = ADDU8; PC_D = 32'h3030;
      #1;
      chk("seq stall before reset", {31'd0, stall_D}, 1);
      reset = 1'b0;
      tick();
      chk("seq rst IR_E", IR_E, 0);
      chk("seq rst PC_E", PC_E, 0);
      chk("seq rst valid_E", {31'd0, valid_E}, 0);
      chk("seq rst stall_D", {31'd0, stall_D}, 0);
`ifdef BUBBLE_CNT_EN
      chk("seq rst bubble_cnt", bubble_cnt, 0);
`endif
      reset = 1'b1;
      tick();
      chk("seq held IR_E", IR_E, ADDU8);
      chk("seq held PC_E", PC_E, 32'h3030);
      chk("seq held dst_E", {27'd0, dst_E}, 9);
      chk("seq held valid_E", {31'd0, valid_E}, 1);

`ifdef BUBBLE_CNT_EN
      force dut.bubble_cnt = 32'hFFFFFFFE;
      #1;
      release dut.bubble_cnt;
      flush_in = 1'b1;
      tick();
      chk("sat reach max", bubble_cnt, 32'hFFFFFFFF);
      tick();
      chk("sat hold max", bubble_cnt, 32'hFFFFFFFF);
      flush_in = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL provide ports (name  direction  width  meaning): clk  in  1  sole clock, rising edge; one clock, reset synchronous and active-low.
REQ-002 reset  in  1  synchronous, active-low (0 = reset, sampled on rising clk).
REQ-003 PC_D, IR_D, RD1_D, RD2_D, imm_D  in  32 each  decode-stage PC, instruction, GRF read data (already W-bypassed inside GRF), extended immediate.
REQ-004 flush_in  in  1  turn the next E-stage slot into a bubble.
REQ-005 we_M  in  1, wa_M  in  5, wd_M  in  32  MEM-stage write-back; we_M asserted only when wd_M is final (never for a load in M).
REQ-006 we_W  in  1, wa_W  in  5, wd_W  in  32  WB-stage write-back.
REQ-007 stall_D  out  1  load-use stall to PC/IF-ID registers.
REQ-008 PC_E, IR_E, imm_E  out  32  registered E-stage PC, instruction, immediate.
REQ-009 RD1_E, RD2_E  out  32  forwarded operands presented to the ALU.
REQ-010 dst_E  out  5  E-stage destination register (0 = none); valid_E  out  1  E slot holds a real instruction.
REQ-011 bubble_cnt  out  32  bubbles inserted (present only with BUBBLE_CNT_EN).

Function
REQ-012 Destination decode from IR: opcode 000000 with nonzero IR -> IR[15:11]; ori (001101), lui (001111), lw (100011) -> IR[20:16]; jal (000011) -> 31; all others (sw, beq, nop) -> 0.
REQ-013 Load-use: stall_D SHALL be 1 combinationally when IR_E opcode = 100011, dst_E != 0, and dst_E equals IR_D[25:21] or IR_D[20:16]; otherwise 0.
REQ-014 On rising clk with reset=1 and stall_D=0 and flush_in=0: PC_E, IR_E, RD1 reg, RD2 reg, imm_E <= D inputs; dst_E <= decode(IR_D); valid_E <= 1.
REQ-015 On rising clk with stall_D=1 or flush_in=1 (either or both): bubble -- all E registers <= 0, valid_E <= 0; D-side inputs not consumed (upstream holds).
REQ-016 Forwarding for RD1_E (source reg rs_E = IR_E[25:21]): if we_M and wa_M != 0 and wa_M = rs_E -> wd_M; else if we_W and wa_W != 0 and wa_W = rs_E -> wd_W; else registered RD1. RD2_E identical using IR_E[20:16].
REQ-017 MEM SHALL have priority over WB when both match; register 0 SHALL never be forwarded.
REQ-018 Latency: D inputs appear on E outputs exactly one clock after capture; forwarding path purely combinational, zero cycles.
REQ-019 Bubble (IR_E=0) SHALL yield RD1_E=RD2_E=0 regardless of M/W writes to register 0.

Reset
REQ-020 reset=0 at a rising edge SHALL clear PC_E, IR_E, imm_E, operand registers, dst_E to 0, valid_E to 0, bubble_cnt to 0; overrides flush_in and stall_D.
REQ-021 Reset mid-stall: after reset release stall_D=0 (IR_E is nop) and the held D instruction is captured on the next edge.

Configuration
REQ-022 Macro BUBBLE_CNT_EN: defined -> 32-bit bubble_cnt increments by 1 on every edge of REQ-015 with reset=1, saturates at 32'hFFFFFFFF; undefined -> port and counter absent, no other behaviour change.

Verification
REQ-023 lw $8,0($0) then addu $9,$8,$8 in D -> stall_D=1 one cycle, next E slot IR_E=0/valid_E=0, then addu captured; with lw in W (wa_W=8, wd_W=32'h1234) RD1_E=RD2_E=32'h1234; bubble_cnt=1.
REQ-024 addu in E with rs=5; we_M=1,wa_M=5,wd_M=32'hAAAA0000 and we_W=1,wa_W=5,wd_W=32'h5555 -> RD1_E=32'hAAAA0000.
REQ-025 we_M=1,wa_M=0,wd_M=32'hFFFFFFFF, E rs=0, registered RD1=0 -> RD1_E=0.
REQ-026 jal at PC_D=32'h3000 -> next cycle PC_E=32'h3000, dst_E=31, valid_E=1; ori $7 -> dst_E=7; sw -> dst_E=0.
REQ-027 flush_in=1 and load-use stall same cycle -> single bubble, bubble_cnt +1; reset=0 asserted during stall -> all outputs 0, stall_D=0 next cycle.
REQ-028 Force bubble_cnt to 32'hFFFFFFFF then flush_in=1 -> stays 32'hFFFFFFFF.
